// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin switch allocator for the mesh router.
// Grants at most one input per output each cycle, with credit-based flow control
// toward the downstream buffers.
// Optional feature macro: SWITCH_ALLOC_WORMHOLE_EN (per-output packet locking).
`ifndef PORT_NUM
`define PORT_NUM 5
`endif

module switch_allocator #(
    parameter int N_PORT  = `PORT_NUM,
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORT-1:0]             req_valid,
    input  logic [N_PORT-1:0][N_PORT-1:0] req_port,
    input  logic [N_PORT-1:0]             req_head,
    input  logic [N_PORT-1:0]             req_tail,
    input  logic [N_PORT-1:0]             credit_in,
    output logic [N_PORT-1:0]             grant_out,
    output logic [N_PORT-1:0][N_PORT-1:0] port_sel,
    output logic [N_PORT-1:0]             out_locked
);
    localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    logic [PTR_W-1:0]  rr_ptr [N_PORT];
    logic [CNT_W-1:0]  credit [N_PORT];
    logic [N_PORT-1:0] elig [N_PORT];
    logic [PTR_W-1:0]  winner [N_PORT];
    logic [N_PORT-1:0] out_granted;
    logic [N_PORT-1:0] ptr_adv;

`ifdef SWITCH_ALLOC_WORMHOLE_EN
    typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t      lock_q  [N_PORT];
    lock_state_t      lock_d  [N_PORT];
    logic [PTR_W-1:0] owner_q [N_PORT];
    logic [PTR_W-1:0] owner_d [N_PORT];

    // An input may compete for an output only if it has credit and obeys the output's lock
    always_comb begin
        elig = '{default: '0};
        for (int o = 0; o < N_PORT; o++) begin
            for (int i = 0; i < N_PORT; i++) begin
                elig[o][i] = req_valid[i] && req_port[i][o] && (credit[o] != '0);
                if (lock_q[o] == LOCKED)
                    elig[o][i] = elig[o][i] && (owner_q[o] == PTR_W'(i));
                else
                    elig[o][i] = elig[o][i] && req_head[i];
            end
        end
    end

    // Lock next state: a head without tail claims the output, the owner's tail releases it
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        for (int o = 0; o < N_PORT; o++) begin
            if (out_granted[o]) begin
                if (lock_q[o] == FREE) begin
                    if (req_head[winner[o]] && !req_tail[winner[o]]) begin
                        lock_d[o]  = LOCKED;
                        owner_d[o] = winner[o];
                    end
                end else if (req_tail[winner[o]]) begin
                    lock_d[o] = FREE;
                end
            end
        end
    end

    // Lock state register; reset drops every in-flight reservation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < N_PORT; o++) begin
                lock_q[o]  <= FREE;
                owner_q[o] <= '0;
            end
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    // Reservation status and pointer movement, which happens only at packet end
    always_comb begin
        out_locked = '0;
        ptr_adv    = '0;
        for (int o = 0; o < N_PORT; o++) begin
            out_locked[o] = (lock_q[o] == LOCKED);
            ptr_adv[o]    = req_tail[winner[o]];
        end
    end
`else
    logic unused_flit_flags;
    assign unused_flit_flags = ^{req_head, req_tail};

    // Without locking every flit competes on its own, limited only by credits
    always_comb begin
        elig = '{default: '0};
        for (int o = 0; o < N_PORT; o++) begin
            for (int i = 0; i < N_PORT; i++) begin
                elig[o][i] = req_valid[i] && req_port[i][o] && (credit[o] != '0);
            end
        end
    end

    // No reservations exist, and the pointer moves after every grant
    always_comb begin
        out_locked = '0;
        ptr_adv    = '1;
    end
`endif

    // Round-robin pick per output, scanning upward from its pointer with wrap-around
    always_comb begin
        int idx;
        idx         = 0;
        grant_out   = '0;
        port_sel    = '0;
        out_granted = '0;
        winner      = '{default: '0};
        for (int o = 0; o < N_PORT; o++) begin
            for (int k = 0; k < N_PORT; k++) begin
                idx = (int'(rr_ptr[o]) + k) % N_PORT;
                if (!out_granted[o] && elig[o][idx]) begin
                    out_granted[o] = 1'b1;
                    winner[o]      = PTR_W'(idx);
                end
            end
            if (out_granted[o]) begin
                port_sel[winner[o]][o] = 1'b1;
                grant_out[winner[o]]   = 1'b1;
            end
        end
    end

    // Pointer and credit registers; a grant and a returned credit in one cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < N_PORT; o++) begin
                rr_ptr[o] <= '0;
                credit[o] <= CNT_W'(CREDITS);
            end
        end else begin
            for (int o = 0; o < N_PORT; o++) begin
                if (out_granted[o] && ptr_adv[o])
                    rr_ptr[o] <= (winner[o] == PTR_W'(N_PORT - 1)) ? '0 : winner[o] + 1'b1;
                if (out_granted[o] && !credit_in[o])
                    credit[o] <= credit[o] - 1'b1;
                else if (!out_granted[o] && credit_in[o] && (credit[o] != CNT_W'(CREDITS)))
                    credit[o] <= credit[o] + 1'b1;
            end
        end
    end

    // Simulation checks: at most one requested output per input, no credit beyond buffer depth
    generate
        for (genvar g = 0; g < N_PORT; g++) begin : g_chk
            a_req_onehot: assert property (@(posedge clk) disable iff (reset)
                req_valid[g] |-> $onehot0(req_port[g]));
            a_credit_ovf: assert property (@(posedge clk) disable iff (reset)
                !(credit_in[g] && !out_granted[g] && (credit[g] == CNT_W'(CREDITS))));
        end
    endgenerate
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed scenarios plus randomized packet traffic checked
// against a behavioural model of the allocator.
module tb_switch_allocator;
    localparam int N  = 5;
    localparam int CR = 4;
`ifdef SWITCH_ALLOC_WORMHOLE_EN
    localparam bit WH = 1'b1;
`else
    localparam bit WH = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req_valid, req_head, req_tail, credit_in;
    logic [N-1:0]        grant_out, out_locked;
    logic [N-1:0][N-1:0] req_port, port_sel;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int                  m_ptr [N];
    int                  m_owner [N];
    int                  m_credit [N];
    bit                  m_locked [N];
    bit                  exp_hit [N];
    int                  exp_win [N];
    logic [N-1:0]        exp_grant, exp_locked;
    logic [N-1:0][N-1:0] exp_sel;

    switch_allocator #(.N_PORT(N), .CREDITS(CR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_port  (req_port),
        .req_head  (req_head),
        .req_tail  (req_tail),
        .credit_in (credit_in),
        .grant_out (grant_out),
        .port_sel  (port_sel),
        .out_locked(out_locked)
    );

    // Free-running router clock
    always #5 clk = ~clk;

    task automatic clear_inputs();
        req_valid = '0;
        req_port  = '0;
        req_head  = '0;
        req_tail  = '0;
        credit_in = '0;
    endtask

    task automatic set_req(input int i, input int o, input bit head, input bit tail);
        req_valid[i]   = 1'b1;
        req_port[i]    = '0;
        req_port[i][o] = 1'b1;
        req_head[i]    = head;
        req_tail[i]    = tail;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Expected outcome of the current cycle, from the allocation rules
    task automatic model_eval();
        exp_grant = '0;
        exp_sel   = '0;
        for (int o = 0; o < N; o++) begin
            exp_hit[o]    = 1'b0;
            exp_win[o]    = 0;
            exp_locked[o] = m_locked[o];
            if (m_credit[o] > 0) begin
                for (int k = 0; k < N; k++) begin
                    int  i;
                    bit  ok;
                    i  = (m_ptr[o] + k) % N;
                    ok = req_valid[i] && req_port[i][o];
                    if (WH) ok = ok && (m_locked[o] ? (i == m_owner[o]) : req_head[i]);
                    if (ok) begin
                        exp_hit[o]      = 1'b1;
                        exp_win[o]      = i;
                        exp_grant[i]    = 1'b1;
                        exp_sel[i][o]   = 1'b1;
                        break;
                    end
                end
            end
        end
    endtask

    // Advance the model state at the clock edge
    task automatic model_commit();
        for (int o = 0; o < N; o++) begin
            int c;
            int w;
            c = m_credit[o];
            w = exp_win[o];
            if (exp_hit[o]) begin
                c = c - 1;
                if (WH) begin
                    if (!m_locked[o] && req_head[w] && !req_tail[w]) begin
                        m_locked[o] = 1'b1;
                        m_owner[o]  = w;
                    end else if (m_locked[o] && req_tail[w]) begin
                        m_locked[o] = 1'b0;
                    end
                end
                if (!WH || req_tail[w]) m_ptr[o] = (w + 1) % N;
            end
            if (credit_in[o]) c = c + 1;
            if (c > CR) c = CR;
            m_credit[o] = c;
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_ptr[o]    = 0;
            m_owner[o]  = 0;
            m_credit[o] = CR;
            m_locked[o] = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [N-1:0][N-1:0] want_sel;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant_out !== '0) begin errors++; $display("[TB] FAIL reset_grant got=%b want=0", grant_out); end
        checks++;
        if (port_sel !== '0) begin errors++; $display("[TB] FAIL reset_sel got=%b want=0", port_sel); end
        checks++;
        if (out_locked !== '0) begin errors++; $display("[TB] FAIL reset_locked got=%b want=0", out_locked); end
        @(posedge clk);
        #1 reset = 1'b0;
        set_req(0, 0, 1'b1, 1'b1);
        want_sel       = '0;
        want_sel[0][0] = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b00001) begin errors++; $display("[TB] FAIL post_reset_grant got=%b want=00001", grant_out); end
        checks++;
        if (port_sel !== want_sel) begin errors++; $display("[TB] FAIL post_reset_sel got=%b want=%b", port_sel, want_sel); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0][N-1:0] want_sel;
        do_reset();
        set_req(0, 2, 1'b1, 1'b1);
        set_req(3, 2, 1'b1, 1'b1);
        want_sel       = '0;
        want_sel[0][2] = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b00001) begin errors++; $display("[TB] FAIL rr_first got=%b want=00001", grant_out); end
        checks++;
        if (port_sel !== want_sel) begin errors++; $display("[TB] FAIL rr_first_sel got=%b want=%b", port_sel, want_sel); end
        next_cycle();
        set_req(3, 2, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b01000) begin errors++; $display("[TB] FAIL rr_second got=%b want=01000", grant_out); end
        next_cycle();
        // Pointer of output 2 should now sit at input 4
        set_req(0, 2, 1'b1, 1'b1);
        set_req(4, 2, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b10000) begin errors++; $display("[TB] FAIL rr_ptr4 got=%b want=10000", grant_out); end
        next_cycle();
    endtask

`ifdef SWITCH_ALLOC_WORMHOLE_EN
    task automatic test_wormhole();
        logic [N-1:0] want_g [4];
        logic [N-1:0] want_l [4];
        want_g = '{5'b00010, 5'b00010, 5'b00010, 5'b00100};
        want_l = '{5'b00000, 5'b10000, 5'b10000, 5'b00000};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c < 3) set_req(1, 4, c == 0, c == 2);
            set_req(2, 4, 1'b1, 1'b1);
            @(negedge clk);
            checks++;
            if (grant_out !== want_g[c]) begin errors++; $display("[TB] FAIL worm_grant c=%0d got=%b want=%b", c, grant_out, want_g[c]); end
            checks++;
            if (out_locked !== want_l[c]) begin errors++; $display("[TB] FAIL worm_locked c=%0d got=%b want=%b", c, out_locked, want_l[c]); end
            next_cycle();
        end
    endtask

    task automatic test_owner_bubble();
        do_reset();
        set_req(1, 4, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b00010) begin errors++; $display("[TB] FAIL bubble_head got=%b want=00010", grant_out); end
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            set_req(2, 4, 1'b1, 1'b1);
            @(negedge clk);
            checks++;
            if (grant_out !== 5'b00000) begin errors++; $display("[TB] FAIL bubble_grant c=%0d got=%b want=00000", c, grant_out); end
            checks++;
            if (out_locked !== 5'b10000) begin errors++; $display("[TB] FAIL bubble_locked c=%0d got=%b want=10000", c, out_locked); end
            next_cycle();
        end
        set_req(1, 4, 1'b0, 1'b1);
        set_req(2, 4, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b00010) begin errors++; $display("[TB] FAIL bubble_tail got=%b want=00010", grant_out); end
        next_cycle();
        set_req(2, 4, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b00100) begin errors++; $display("[TB] FAIL bubble_next got=%b want=00100", grant_out); end
        next_cycle();
        // A body flit aimed at a free output is never granted
        set_req(3, 1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_out !== 5'b00000) begin errors++; $display("[TB] FAIL body_to_free got=%b want=00000", grant_out); end
        next_cycle();
    endtask
`else
    task automatic test_independent_rr();
        logic [N-1:0] want_g [3];
        want_g = '{5'b00010, 5'b00100, 5'b00010};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_req(1, 4, 1'b0, 1'b0);
            set_req(2, 4, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (grant_out !== want_g[c]) begin errors++; $display("[TB] FAIL indep_grant c=%0d got=%b want=%b", c, grant_out, want_g[c]); end
            checks++;
            if (out_locked !== '0) begin errors++; $display("[TB] FAIL indep_locked c=%0d got=%b want=0", c, out_locked); end
            next_cycle();
        end
    endtask
`endif

    task automatic test_credits();
        bit want_g [11];
        bit ci [11];
        want_g = '{1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 0};
        ci     = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 11; c++) begin
            set_req(0, 0, 1'b1, 1'b1);
            credit_in[0] = ci[c];
            @(negedge clk);
            checks++;
            if (grant_out !== (want_g[c] ? 5'b00001 : 5'b00000))
                begin errors++; $display("[TB] FAIL credit_grant c=%0d got=%b want=%0d", c, grant_out, want_g[c]); end
            next_cycle();
        end
    endtask

    task automatic test_parallel();
        int                  perm [N];
        logic [N-1:0][N-1:0] want_sel;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) perm[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                int j;
                int tmp;
                j       = int'($urandom_range(0, i));
                tmp     = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            want_sel = '0;
            for (int i = 0; i < N; i++) begin
                set_req(i, perm[i], 1'b1, 1'b1);
                want_sel[i][perm[i]] = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (grant_out !== 5'b11111) begin errors++; $display("[TB] FAIL parallel_grant t=%0d got=%b want=11111", t, grant_out); end
            checks++;
            if (port_sel !== want_sel) begin errors++; $display("[TB] FAIL parallel_sel t=%0d got=%b want=%b", t, port_sel, want_sel); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            set_req(2, 3, WH ? (c == 0) : 1'b1, WH ? 1'b0 : 1'b1);
            @(negedge clk);
            checks++;
            if (grant_out !== 5'b00100) begin errors++; $display("[TB] FAIL midpkt_grant c=%0d got=%b want=00100", c, grant_out); end
            next_cycle();
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        // Full credits are back: exactly four grants, then a stall
        for (int c = 0; c < 5; c++) begin
            set_req(4, 3, 1'b1, 1'b1);
            @(negedge clk);
            checks++;
            if (out_locked !== '0) begin errors++; $display("[TB] FAIL midpkt_locked c=%0d got=%b want=0", c, out_locked); end
            checks++;
            if (grant_out !== ((c < 4) ? 5'b10000 : 5'b00000))
                begin errors++; $display("[TB] FAIL midpkt_after c=%0d got=%b", c, grant_out); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int pkt_dest [N];
        int pkt_len [N];
        int pkt_pos [N];
        do_reset();
        model_reset();
        for (int i = 0; i < N; i++) begin
            pkt_dest[i] = int'($urandom_range(0, N - 1));
            pkt_len[i]  = int'($urandom_range(1, 4));
            pkt_pos[i]  = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_inputs();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 7)
                    set_req(i, pkt_dest[i], pkt_pos[i] == 0, pkt_pos[i] == pkt_len[i] - 1);
                else if ($urandom_range(0, 9) == 0)
                    req_valid[i] = 1'b1;
            end
            model_eval();
            for (int o = 0; o < N; o++)
                if (m_credit[o] < CR && $urandom_range(0, 1) == 1) credit_in[o] = 1'b1;
            @(negedge clk);
            checks++;
            if (grant_out !== exp_grant) begin errors++; $display("[TB] FAIL rand_grant cyc=%0d got=%b want=%b", cyc, grant_out, exp_grant); end
            checks++;
            if (port_sel !== exp_sel) begin errors++; $display("[TB] FAIL rand_sel cyc=%0d got=%b want=%b", cyc, port_sel, exp_sel); end
            checks++;
            if (out_locked !== exp_locked) begin errors++; $display("[TB] FAIL rand_locked cyc=%0d got=%b want=%b", cyc, out_locked, exp_locked); end
            model_commit();
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    pkt_pos[i]++;
                    if (pkt_pos[i] == pkt_len[i]) begin
                        pkt_dest[i] = int'($urandom_range(0, N - 1));
                        pkt_len[i]  = int'($urandom_range(1, 4));
                        pkt_pos[i]  = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Scenario sequence and final summary
    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_round_robin();
`ifdef SWITCH_ALLOC_WORMHOLE_EN
        test_wormhole();
        test_owner_bubble();
`else
        test_independent_rr();
`endif
        test_credits();
        test_parallel();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
